// File: rtl/pipeline_control_sequencer.sv
// pipeline_control_sequencer: stall/flush/freeze sequencer for the 5-stage pipeline.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_control_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hazard_stall_n,
  input  logic        redirect_req,
  input  logic        dmem_req,
  input  logic        dmem_busy,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        if_id_flush,
  output logic        id_ex_we,
  output logic        id_ex_bubble,
  output logic        ex_mem_we,
  output logic        mem_wb_bubble,
  output logic [1:0]  ctrl_state,
  output logic        mem_timeout_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] freeze_cnt
);
  localparam logic [1:0] RUN = 2'd0, FLUSH = 2'd1, HAZ = 2'd2, MEMW = 2'd3;
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MEM_TIMEOUT);
  logic [1:0] state, state_nx;
  logic flush_pend, pend_nx;
  logic [CNT_W-1:0] wait_cnt;
  logic freeze, haz, redir, resume;
  assign freeze = dmem_req & dmem_busy;
  assign haz = (state != FLUSH) & ~hazard_stall_n;
  assign redir = (state != FLUSH) & redirect_req & ~haz;
  assign resume = (state == MEMW) & flush_pend;
  assign ctrl_state = state;
  always_comb begin
    pc_we = 1'b0;
    if_id_we = 1'b0;
    if_id_flush = 1'b0;
    id_ex_we = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_we = 1'b0;
    mem_wb_bubble = 1'b0;
    if (!rst_n) begin
      if_id_flush = 1'b1;
      id_ex_bubble = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (freeze) begin
      mem_wb_bubble = 1'b1;
    end else if (haz) begin
      id_ex_we = 1'b1;
      id_ex_bubble = 1'b1;
      ex_mem_we = 1'b1;
    end else begin
      pc_we = 1'b1;
      if_id_we = 1'b1;
      id_ex_we = 1'b1;
      ex_mem_we = 1'b1;
      if_id_flush = (state == FLUSH) | redir;
    end
  end
  // A freeze landing between the two flush cycles parks the second one in flush_pend.
  always_comb begin
    state_nx = freeze ? MEMW : resume ? FLUSH : haz ? HAZ : redir ? FLUSH : RUN;
    pend_nx = freeze ? (flush_pend | (state == FLUSH) | redir) : resume ? 1'b0 : flush_pend;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      flush_pend <= 1'b0;
      wait_cnt <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      flush_pend <= pend_nx;
      wait_cnt <= !freeze ? '0 : (wait_cnt == TIMEOUT) ? wait_cnt : wait_cnt + 1'b1;
      mem_timeout_err <= mem_timeout_err | (freeze & (wait_cnt == TIMEOUT));
    end
  end
`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      freeze_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + {31'd0, haz & ~freeze};
      flush_cnt <= flush_cnt + {31'd0, if_id_flush};
      freeze_cnt <= freeze_cnt + {31'd0, freeze};
    end
  end
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
  assign freeze_cnt = 32'd0;
`endif
endmodule
